// File: rtl/snake_body.sv
// Snake position, direction, growth and collision FSM with combinational snake pixel colour.
// Moves once every TICK_DIV clocks in RUN; move_tick is high in the cycle that commits a move.
module snake_body #(
   parameter int SCREEN_WIDTH     = 640,
   parameter int SCREEN_HEIGHT    = 480,
   parameter int CELL_SIZE        = 10,
   parameter int BORDER_THICKNESS = 20,
   parameter int MAX_LEN          = 16,
   parameter int START_LEN        = 3,
   parameter int START_X          = 320,
   parameter int START_Y          = 240,
   parameter int TICK_DIV         = 2500000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic [11:0] x,
   input  logic [11:0] y,
   input  logic [11:0] food_x,
   input  logic [11:0] food_y,
   output logic [11:0] snake_x,
   output logic [11:0] snake_y,
   output logic [11:0] snake_size,
   output logic [7:0]  length,
   output logic        move_tick,
   output logic        game_over,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b
);

   localparam int                CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]     CNT_LAST  = CW'(TICK_DIV - 1);
   localparam logic [11:0]       CELL      = 12'(CELL_SIZE);
   localparam logic [11:0]       WALL_LO   = 12'(BORDER_THICKNESS);
   localparam logic [11:0]       WALL_X_HI = 12'(SCREEN_WIDTH - BORDER_THICKNESS);
   localparam logic [11:0]       WALL_Y_HI = 12'(SCREEN_HEIGHT - BORDER_THICKNESS);
   localparam logic [7:0]        LEN_START = 8'(START_LEN);
   localparam logic [7:0]        LEN_MAX   = 8'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
   typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;

   state_t        r_state;
   state_t        w_state_nxt;
   dir_t          r_dir;
   dir_t          r_pend;
   dir_t          w_req_dir;
   logic [CW-1:0] r_cnt;
   logic          r_grow;
   logic [7:0]    r_len;
   logic [11:0]   r_seg_x [MAX_LEN];
   logic [11:0]   r_seg_y [MAX_LEN];

   logic          w_run;
   logic          w_move;
   logic          w_restart;
   logic          w_req_vld;
   logic          w_req_ok;
   logic [11:0]   w_new_x;
   logic [11:0]   w_new_y;
   logic          w_wall_hit;
   logic          w_self_hit;
   logic          w_hit;
   logic [7:0]    w_self_limit;
   logic          w_eat;
   logic          w_in_head;
   logic          w_in_body;

   function automatic dir_t f_opposite(input dir_t d);
      case (d)
         D_RIGHT: f_opposite = D_LEFT;
         D_LEFT:  f_opposite = D_RIGHT;
         D_UP:    f_opposite = D_DOWN;
         default: f_opposite = D_UP;
      endcase
   endfunction

   function automatic logic f_in_box(input logic [11:0] px, input logic [11:0] py,
                                     input logic [11:0] bx, input logic [11:0] by);
      f_in_box = (px >= bx) && (px < bx + CELL) && (py >= by) && (py < by + CELL);
   endfunction

   function automatic logic [11:0] f_init_x(input int i);
      f_init_x = (i < START_LEN) ? 12'(START_X - i * CELL_SIZE) : 12'd0;
   endfunction

   function automatic logic [11:0] f_init_y(input int i);
      f_init_y = (i < START_LEN) ? 12'(START_Y) : 12'd0;
   endfunction

   assign w_run     = (r_state == S_RUN);
   assign w_move    = w_run && (r_cnt == CNT_LAST);
   assign w_restart = (r_state == S_OVER) && start;

   // Highest-priority pressed button wins; a reversal request is dropped, not demoted.
   always_comb begin
      w_req_vld = 1'b1;
      w_req_dir = D_RIGHT;
      if (btn_up)         w_req_dir = D_UP;
      else if (btn_down)  w_req_dir = D_DOWN;
      else if (btn_left)  w_req_dir = D_LEFT;
      else if (btn_right) w_req_dir = D_RIGHT;
      else                w_req_vld = 1'b0;
      w_req_ok = w_req_vld && (w_req_dir != f_opposite(r_dir));
   end

   always_comb begin
      w_new_x = r_seg_x[0];
      w_new_y = r_seg_y[0];
      case (r_pend)
         D_RIGHT: w_new_x = r_seg_x[0] + CELL;
         D_LEFT:  w_new_x = r_seg_x[0] - CELL;
         D_UP:    w_new_y = r_seg_y[0] - CELL;
         default: w_new_y = r_seg_y[0] + CELL;
      endcase
   end

   assign w_wall_hit = (w_new_x < WALL_LO) || (w_new_x + CELL > WALL_X_HI) ||
                       (w_new_y < WALL_LO) || (w_new_y + CELL > WALL_Y_HI);

   // The tail vacates on a plain move, so it only counts when the snake is about to grow.
   always_comb begin
      w_self_limit = r_grow ? r_len : r_len - 8'd1;
      w_self_hit   = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if ((8'(i) < w_self_limit) && (r_seg_x[i] == w_new_x) && (r_seg_y[i] == w_new_y))
            w_self_hit = 1'b1;
      end
   end

   assign w_hit = w_wall_hit || w_self_hit;

   assign w_eat = w_run &&
                  (r_seg_x[0] < food_x + CELL) && (food_x < r_seg_x[0] + CELL) &&
                  (r_seg_y[0] < food_y + CELL) && (food_y < r_seg_y[0] + CELL);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start)          w_state_nxt = S_RUN;
         S_RUN:   if (w_move && w_hit) w_state_nxt = S_OVER;
         S_OVER:  if (start)          w_state_nxt = S_IDLE;
         default:                     w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_len  <= LEN_START;
         r_dir  <= D_RIGHT;
         r_pend <= D_RIGHT;
         r_cnt  <= '0;
         r_grow <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            r_seg_x[i] <= f_init_x(i);
            r_seg_y[i] <= f_init_y(i);
         end
      end else if (w_restart) begin
         r_len  <= LEN_START;
         r_dir  <= D_RIGHT;
         r_pend <= D_RIGHT;
         r_cnt  <= '0;
         r_grow <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            r_seg_x[i] <= f_init_x(i);
            r_seg_y[i] <= f_init_y(i);
         end
      end else begin
         if (!w_run || w_move) r_cnt <= '0;
         else                  r_cnt <= r_cnt + 1'b1;

         if (w_run && w_req_ok) r_pend <= w_req_dir;

         if (w_move && !w_hit) begin
            r_dir <= r_pend;
            for (int i = MAX_LEN - 1; i >= 1; i--) begin
               r_seg_x[i] <= r_seg_x[i-1];
               r_seg_y[i] <= r_seg_y[i-1];
            end
            r_seg_x[0] <= w_new_x;
            r_seg_y[0] <= w_new_y;
            if (r_grow && (r_len < LEN_MAX)) r_len <= r_len + 8'd1;
         end

         // Food relocates right after being eaten, so the request must be held until a move.
         if (w_eat)                  r_grow <= 1'b1;
         else if (w_move && !w_hit)  r_grow <= 1'b0;
      end
   end

   always_comb begin
      w_in_head = f_in_box(x, y, r_seg_x[0], r_seg_y[0]);
      w_in_body = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if ((8'(i) < r_len) && f_in_box(x, y, r_seg_x[i], r_seg_y[i]))
            w_in_body = 1'b1;
      end
      vga_r = 8'd0;
      vga_g = 8'd0;
      vga_b = 8'd0;
      if (w_in_head) begin
         vga_r = 8'd255;
         vga_g = 8'd255;
      end else if (w_in_body) begin
         vga_g = 8'd255;
      end
   end

   assign snake_x    = r_seg_x[0];
   assign snake_y    = r_seg_y[0];
   assign snake_size = CELL;
   assign length     = r_len;
   assign move_tick  = w_move;
   assign game_over  = (r_state == S_OVER);

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: directed vector table, reset corner case, then random play against a queue model.
module tb_snake_body;
   localparam int TICK = 4;
   localparam int MAXL = 16;

   logic        CLOCK_50 = 1'b0;
   logic        reset, start, btn_up, btn_down, btn_left, btn_right;
   logic [11:0] x, y, food_x, food_y;
   logic [11:0] snake_x, snake_y, snake_size;
   logic [7:0]  length, vga_r, vga_g, vga_b;
   logic        move_tick, game_over;

   int checks = 0;
   int errors = 0;

   snake_body #(.TICK_DIV(TICK)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .x(x), .y(y), .food_x(food_x), .food_y(food_y),
      .snake_x(snake_x), .snake_y(snake_y), .snake_size(snake_size), .length(length),
      .move_tick(move_tick), .game_over(game_over),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Reference model: body as a queue of cells, head at index 0.
   int mq_x[$];
   int mq_y[$];
   int m_state;  // 0 idle, 1 run, 2 over
   int m_cnt, m_dir, m_pend;
   bit m_grow;

   function automatic int m_opp(input int d);
      case (d)
         0: return 1;
         1: return 0;
         2: return 3;
         default: return 2;
      endcase
   endfunction

   task automatic m_init();
      mq_x.delete();
      mq_y.delete();
      for (int i = 0; i < 3; i++) begin
         mq_x.push_back(320 - 10 * i);
         mq_y.push_back(240);
      end
      m_state = 0; m_cnt = 0; m_dir = 0; m_pend = 0; m_grow = 1'b0;
   endtask

   task automatic m_step();
      int  req, old_pend, nx, ny, lim, fx, fy;
      bit  eat, hit;
      case (m_state)
         0: if (start) begin m_state = 1; m_cnt = 0; end
         2: if (start) m_init();
         default: begin
            fx = int'(food_x);
            fy = int'(food_y);
            eat = (mq_x[0] < fx + 10) && (fx < mq_x[0] + 10) &&
                  (mq_y[0] < fy + 10) && (fy < mq_y[0] + 10);
            req = -1;
            if (btn_up)         req = 2;
            else if (btn_down)  req = 3;
            else if (btn_left)  req = 1;
            else if (btn_right) req = 0;
            old_pend = m_pend;
            if (req >= 0 && req != m_opp(m_dir)) m_pend = req;
            if (m_cnt == TICK - 1) begin
               m_cnt = 0;
               nx = mq_x[0];
               ny = mq_y[0];
               case (old_pend)
                  0: nx += 10;
                  1: nx -= 10;
                  2: ny -= 10;
                  default: ny += 10;
               endcase
               hit = (nx < 20) || (nx + 10 > 620) || (ny < 20) || (ny + 10 > 460);
               lim = m_grow ? mq_x.size() : mq_x.size() - 1;
               for (int i = 1; i < lim; i++)
                  if (mq_x[i] == nx && mq_y[i] == ny) hit = 1'b1;
               if (hit) m_state = 2;
               else begin
                  m_dir = old_pend;
                  mq_x.push_front(nx);
                  mq_y.push_front(ny);
                  if (!(m_grow && mq_x.size() <= MAXL)) begin
                     void'(mq_x.pop_back());
                     void'(mq_y.pop_back());
                  end
                  m_grow = 1'b0;
               end
            end else m_cnt++;
            if (eat) m_grow = 1'b1;
         end
      endcase
   endtask

   function automatic int m_pix(input int px, input int py);
      if (px >= mq_x[0] && px < mq_x[0] + 10 && py >= mq_y[0] && py < mq_y[0] + 10)
         return 'hFFFF00;
      for (int i = 1; i < mq_x.size(); i++)
         if (px >= mq_x[i] && px < mq_x[i] + 10 && py >= mq_y[i] && py < mq_y[i] + 10)
            return 'h00FF00;
      return 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic cycle();
      m_step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic cmp_model();
      int k, px, py;
      chk("model head_x", int'(snake_x), mq_x[0]);
      chk("model head_y", int'(snake_y), mq_y[0]);
      chk("model length", int'(length), mq_x.size());
      chk("model game_over", int'(game_over), int'(m_state == 2));
      chk("model move_tick", int'(move_tick), int'(m_state == 1 && m_cnt == TICK - 1));
      chk("snake_size", int'(snake_size), 10);
      k  = int'($urandom_range(0, mq_x.size() - 1));
      px = mq_x[k] + int'($urandom_range(0, 11)) - 1;
      py = mq_y[k] + int'($urandom_range(0, 11)) - 1;
      x = 12'(px);
      y = 12'(py);
      #1;
      chk("model pixel", int'({vga_r, vga_g, vga_b}), m_pix(px, py));
   endtask

   typedef struct {
      int st, btn, fx, fy, cyc;
      int ex, ey, elen, eover, eticks;
      int px, py, epix;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int ticks, b, fx, fy, d;

      // btn field packs {up, down, left, right}
      tbl[0]  = '{0, 0, 0,   0,   20,  320, 240, 3, 0, 0,  325, 245, 'hFFFF00};
      tbl[1]  = '{1, 0, 0,   0,   1,   320, 240, 3, 0, 0,  312, 249, 'h00FF00};
      tbl[2]  = '{0, 0, 0,   0,   3,   320, 240, 3, 0, 1,  300, 240, 'h00FF00};
      tbl[3]  = '{0, 0, 0,   0,   1,   330, 240, 3, 0, 0,  322, 242, 'h00FF00};
      tbl[4]  = '{0, 2, 0,   0,   4,   340, 240, 3, 0, 1,  319, 245, 0};
      tbl[5]  = '{0, 8, 0,   0,   4,   340, 230, 3, 0, 1,  345, 235, 'hFFFF00};
      tbl[6]  = '{0, 0, 340, 220, 4,   340, 220, 3, 0, 1,  345, 249, 'h00FF00};
      tbl[7]  = '{0, 0, 340, 220, 1,   340, 220, 3, 0, 0,  345, 250, 0};
      tbl[8]  = '{0, 0, 0,   0,   3,   340, 210, 4, 0, 1,  345, 245, 'h00FF00};
      tbl[9]  = '{0, 0, 0,   0,   76,  340, 20,  4, 0, 19, 345, 55,  'h00FF00};
      tbl[10] = '{0, 0, 0,   0,   4,   340, 20,  4, 1, 1,  345, 25,  'hFFFF00};
      tbl[11] = '{0, 0, 0,   0,   8,   340, 20,  4, 1, 0,  341, 60,  0};
      tbl[12] = '{1, 0, 0,   0,   1,   320, 240, 3, 0, 0,  301, 249, 'h00FF00};
      tbl[13] = '{1, 0, 0,   0,   1,   320, 240, 3, 0, 0,  299, 245, 0};
      tbl[14] = '{0, 0, 0,   0,   116, 610, 240, 3, 0, 29, 600, 240, 'h00FF00};
      tbl[15] = '{0, 0, 0,   0,   4,   610, 240, 3, 1, 1,  619, 249, 'hFFFF00};

      reset = 1'b1; start = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      x = '0; y = '0; food_x = '0; food_y = '0;
      m_init();
      #12 reset = 1'b0;

      for (int r = 0; r < 16; r++) begin
         start = (tbl[r].st != 0);
         {btn_up, btn_down, btn_left, btn_right} = 4'(tbl[r].btn);
         food_x = 12'(tbl[r].fx);
         food_y = 12'(tbl[r].fy);
         ticks = 0;
         for (int c = 0; c < tbl[r].cyc; c++) begin
            cycle();
            if (move_tick) ticks++;
         end
         chk($sformatf("row%0d head_x", r), int'(snake_x), tbl[r].ex);
         chk($sformatf("row%0d head_y", r), int'(snake_y), tbl[r].ey);
         chk($sformatf("row%0d length", r), int'(length), tbl[r].elen);
         chk($sformatf("row%0d game_over", r), int'(game_over), tbl[r].eover);
         chk($sformatf("row%0d move_ticks", r), ticks, tbl[r].eticks);
         x = 12'(tbl[r].px);
         y = 12'(tbl[r].py);
         #1;
         chk($sformatf("row%0d pixel", r), int'({vga_r, vga_g, vga_b}), tbl[r].epix);
      end

      // Asynchronous reset between ticks, then confirm the counter restarts from zero.
      start = 1'b1;
      cycle();
      cycle();
      start = 1'b0;
      repeat (7) cycle();
      chk("pre_reset head_x", int'(snake_x), 330);
      chk("pre_reset move_tick", int'(move_tick), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset head_x", int'(snake_x), 320);
      chk("async_reset length", int'(length), 3);
      chk("async_reset move_tick", int'(move_tick), 0);
      chk("async_reset game_over", int'(game_over), 0);
      m_init();
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (3) cycle();
      chk("post_reset move_tick", int'(move_tick), 1);
      cycle();
      chk("post_reset head_x", int'(snake_x), 330);

      // Random play: food is often dropped on or near the next head cell to force growth.
      b = 0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 11) == 0) begin
            b = int'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) b = 0;
         end
         {btn_up, btn_down, btn_left, btn_right} = 4'(b);
         if (m_state != 1) start = ($urandom_range(0, 7) == 0);
         else              start = ($urandom_range(0, 30) == 0);
         d = int'($urandom_range(0, 5));
         if (d < 2) begin
            fx = mq_x[0];
            fy = mq_y[0];
            case (m_pend)
               0: fx += 10;
               1: fx -= 10;
               2: fy -= 10;
               default: fy += 10;
            endcase
            fx += int'($urandom_range(0, 20)) - 10;
            fy += int'($urandom_range(0, 20)) - 10;
            food_x = 12'(fx);
            food_y = 12'(fy);
         end else if (d == 2) begin
            food_x = '0;
            food_y = '0;
         end
         cycle();
         cmp_model();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
